// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider for the EX stage. Executes DIV (signed) and
//   DIVU (unsigned) by restoring division, one quotient bit per clock, and
//   delivers {remainder, quotient} for the HI/LO write through EX/MEM.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   signed_div_i 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      division request, held high until ready_o is seen
//   annul_i      cancel the in-flight operation (flush/exception)
//   result_o     {remainder, quotient} = {HI, LO}
//   ready_o      result valid
//   stallreq_o   stall request to the pipeline stall controller
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    BY_ZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              neg_quo;
  logic              neg_rem;

  logic              go;
  logic              dividend_neg;
  logic              divisor_neg;
  logic [DATA_W-1:0] abs_dividend;
  logic [DATA_W-1:0] abs_divisor;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              trial_neg;
  logic [DATA_W-1:0] next_rem;
  logic [DATA_W-1:0] next_quo;
  logic [DATA_W-1:0] final_quo;
  logic [DATA_W-1:0] final_rem;

  assign stallreq_o = start_i & ~ready_o;

  assign go           = start_i & ~annul_i;
  assign dividend_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign divisor_neg  = signed_div_i & opdata2_i[DATA_W-1];
  assign abs_dividend = dividend_neg ? -opdata1_i : opdata1_i;
  assign abs_divisor  = divisor_neg  ? -opdata2_i : opdata2_i;

  // quo starts as the dividend and shifts out its MSB into the partial
  // remainder while quotient bits shift in at the bottom. The partial
  // remainder stays below the divisor, so a 33-bit trial difference is
  // negative exactly when its top bit is set.
  assign shifted   = {rem, quo[DATA_W-1]};
  assign trial     = shifted - {1'b0, divisor};
  assign trial_neg = trial[DATA_W];
  assign next_rem  = trial_neg ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign next_quo  = {quo[DATA_W-2:0], ~trial_neg};

  // Sign fix-up on the last iteration; the flags are already zero for DIVU.
  assign final_quo = neg_quo ? -next_quo : next_quo;
  assign final_rem = neg_rem ? -next_rem : next_rem;

  always_ff @(posedge clk) begin
    if (reset) state <= FREE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE: begin
        if (go) state_next = (opdata2_i == '0) ? BY_ZERO : ON;
      end
      BY_ZERO: begin
        state_next = annul_i ? FREE : END;
      end
      ON: begin
        if (annul_i)                state_next = FREE;
        else if (cnt == LAST_CNT)   state_next = END;
      end
      END: begin
        if (!start_i || annul_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (go && opdata2_i != '0) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= abs_dividend;
            divisor <= abs_divisor;
            neg_quo <= dividend_neg ^ divisor_neg;
            neg_rem <= dividend_neg;
          end
        end
        BY_ZERO: begin
          // Division by zero yields an all-zero result with no exception.
          result_o <= '0;
          ready_o  <= ~annul_i;
        end
        ON: begin
          if (annul_i) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            rem <= next_rem;
            quo <= next_quo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              result_o <= {final_rem, final_quo};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
